// File: rtl/add_seq_pkg.sv
// Shared types and defaults for the chunked wide-addition sequencer.
// Optional subtract mode is enabled by defining ADD_SEQ_SUB_EN.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF = 16;
    localparam int K_DEF = 4;

    // Chunk index width, ceil(log2 K), never narrower than one bit
    function automatic int idx_w(input int k);
        return (k > 2) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Operand/result handshake plus the external N-bit adder hookup.
// The sub port exists only when ADD_SEQ_SUB_EN is defined.
interface add_seq_ctrl_if #(
    parameter int N = 16,
    parameter int K = 4
);
    localparam int W = N * K;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef ADD_SEQ_SUB_EN
    logic         sub;
`endif
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N-1:0] add_s;
    logic         add_cout;

`ifdef ADD_SEQ_SUB_EN
    modport slave  (input  start, a, b, cin, sub, add_s, add_cout,
                    output ready, busy, done, s, cout, add_a, add_b, add_cin);
    modport master (output start, a, b, cin, sub, add_s, add_cout,
                    input  ready, busy, done, s, cout, add_a, add_b, add_cin);
`else
    modport slave  (input  start, a, b, cin, add_s, add_cout,
                    output ready, busy, done, s, cout, add_a, add_b, add_cin);
    modport master (output start, a, b, cin, add_s, add_cout,
                    input  ready, busy, done, s, cout, add_a, add_b, add_cin);
`endif

endinterface

// File: rtl/add_seq_opreg.sv
// Operand and accumulator register bank: parallel load on start,
// chunk select by index, one accumulator chunk written per step.
module add_seq_opreg #(
    parameter int N  = 16,
    parameter int K  = 4,
    parameter int IW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic [N*K-1:0] i_a,
    input  logic [N*K-1:0] i_b,
    input  logic           i_step,
    input  logic [IW-1:0]  i_idx,
    input  logic [N-1:0]   i_add_s,
    output logic [N-1:0]   o_a_chunk,
    output logic [N-1:0]   o_b_chunk,
    output logic [N*K-1:0] o_acc
);
    localparam int W = N * K;

    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_load) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
        end else if (i_step) begin
            r_acc[i_idx*N +: N] <= i_add_s;
        end
    end

    assign o_a_chunk = r_a[i_idx*N +: N];
    assign o_b_chunk = r_b[i_idx*N +: N];
    assign o_acc     = r_acc;

endmodule

// File: rtl/add_seq_ctrl.sv
// Drives one external N-bit adder over K cycles, LS chunk first, to form a W-bit sum.
// Define ADD_SEQ_SUB_EN to add the sub port (a - b via inverted b and forced carry-in).
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic clk,
    input  logic rst,
    add_seq_ctrl_if.slave bus
);
    localparam int W  = N * K;
    localparam int IW = idx_w(K);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [W-1:0]  r_s;
    logic          r_cout;
    logic          w_load;
    logic          w_run;
    logic          w_last;
    logic [W-1:0]  w_b_ld;
    logic          w_cin_ld;
    logic [N-1:0]  w_a_chunk;
    logic [N-1:0]  w_b_chunk;
    logic [W-1:0]  w_acc;

    assign w_run  = (r_state == RUN);
    assign w_last = w_run && (r_idx == IW'(K - 1));

`ifdef ADD_SEQ_SUB_EN
    assign w_b_ld   = bus.sub ? ~bus.b : bus.b;
    assign w_cin_ld = bus.sub | bus.cin;
`else
    assign w_b_ld   = bus.b;
    assign w_cin_ld = bus.cin;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: if (bus.start) begin
                w_state_nxt = RUN;
                w_load      = 1'b1;
            end
            RUN:  if (w_last) w_state_nxt = DONE;
            DONE: begin
                w_state_nxt = bus.start ? RUN : IDLE;
                w_load      = bus.start;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_idx   <= '0;
                r_carry <= w_cin_ld;
            end else if (w_run) begin
                r_carry <= bus.add_cout;
                if (!w_last) r_idx <= r_idx + 1'b1;
            end
            // Top chunk comes straight from the adder; lower chunks are already in acc
            if (w_last) begin
                r_s    <= {bus.add_s, w_acc[W-N-1:0]};
                r_cout <= bus.add_cout;
            end
        end
    end

    add_seq_opreg #(.N(N), .K(K), .IW(IW)) u_opreg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_a       (bus.a),
        .i_b       (w_b_ld),
        .i_step    (w_run),
        .i_idx     (r_idx),
        .i_add_s   (bus.add_s),
        .o_a_chunk (w_a_chunk),
        .o_b_chunk (w_b_chunk),
        .o_acc     (w_acc)
    );

    assign bus.ready   = !w_run;
    assign bus.busy    = w_run;
    assign bus.done    = (r_state == DONE);
    assign bus.s       = r_s;
    assign bus.cout    = r_cout;
    assign bus.add_a   = w_run ? w_a_chunk : '0;
    assign bus.add_b   = w_run ? w_b_chunk : '0;
    assign bus.add_cin = w_run & r_carry;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl with a behavioural N-bit adder; covers ADD_SEQ_SUB_EN when defined.
module tb_add_seq_ctrl;
    localparam int N = 16;
    localparam int K = 4;
    localparam int W = N * K;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_s;
        logic         exp_cout;
        logic         all_cin;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   run_cin_cnt;
    vec_t tbl[$];

    always #5 clk = ~clk;

    add_seq_ctrl_if #(.N(N), .K(K)) bus ();

    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{N{1'b0}}, bus.add_cin};

    add_seq_ctrl #(.N(N), .K(K)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic cin, sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 65'd1;
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance one edge, sample 1ns later; adder inputs must be quiet outside RUN
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.busy) begin
            if (bus.add_cin) run_cin_cnt++;
        end else begin
            check("idle_add_zero", 64'({bus.add_a, bus.add_b, bus.add_cin}), 64'd0);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, b, input logic cin, sub);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef ADD_SEQ_SUB_EN
        bus.sub = sub;
`else
        if (sub) $display("note: sub requested without ADD_SEQ_SUB_EN");
`endif
    endtask

    // Waits for done, returns cycle count from the accepting edge
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 3 * K) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input string name, input vec_t v);
        int lat;
        check({name, "_ready"}, 64'(bus.ready), 64'd1);
        drive(v.a, v.b, v.cin, v.sub);
        bus.start   = 1'b1;
        run_cin_cnt = 0;
        tick();
        bus.start = 1'b0;
        check({name, "_busy"}, 64'(bus.busy), 64'd1);
        wait_done(lat);
        check({name, "_lat"}, 64'(lat), 64'(K + 1));
        check({name, "_s"}, bus.s, v.exp_s);
        check({name, "_cout"}, 64'(bus.cout), 64'(v.exp_cout));
        if (v.all_cin) check({name, "_cin_chain"}, 64'(run_cin_cnt), 64'(K));
        tick();
        check({name, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({name, "_s_held"}, bus.s, v.exp_s);
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, b, input logic cin, sub,
                                input logic [W-1:0] es, input logic ec, input logic ac);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.exp_s = es; v.exp_cout = ec; v.all_cin = ac;
        return v;
    endfunction

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [W:0] exp;
        logic [W-1:0] ra, rb;
        logic rc, rs;
        bit saw_done;

        tbl.push_back(mk(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0));
        tbl.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1));
        tbl.push_back(mk(64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0));
        tbl.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1));
        tbl.push_back(mk(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0));
        tbl.push_back(mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0));
        tbl.push_back(mk(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0));
        tbl.push_back(mk(64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0));
`ifdef ADD_SEQ_SUB_EN
        tbl.push_back(mk(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
        tbl.push_back(mk(64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0));
        tbl.push_back(mk(64'd7, 64'd7, 1'b0, 1'b1, 64'd0, 1'b1, 1'b1));
`endif

        rst       = 1'b1;
        bus.start = 1'b0;
        drive('0, '0, 1'b0, 1'b0);
        run_cin_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_s", bus.s, 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_add", 64'({bus.add_a, bus.add_b, bus.add_cin}), 64'd0);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) do_op($sformatf("vec%0d", i), tbl[i]);

        // start during RUN must be ignored
        drive(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        drive(64'hDEAD_BEEF_DEAD_BEEF, 64'h1, 1'b1, 1'b0);
        bus.start = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        tick();
        check("ign_done", 64'(bus.done), 64'd1);
        check("ign_s", bus.s, 64'd7);
        check("ign_cout", 64'(bus.cout), 64'd0);
        tick();
        check("ign_no_restart", 64'(bus.busy), 64'd0);

        // back-to-back: start held in the DONE cycle
        drive(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(lat);
        check("b2b1_s", bus.s, 64'h30);
        drive(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("b2b2_busy", 64'(bus.busy), 64'd1);
        wait_done(lat);
        check("b2b2_lat", 64'(lat), 64'(K + 1));
        check("b2b2_s", bus.s, 64'h0000_0002_0000_0000);
        check("b2b2_cout", 64'(bus.cout), 64'd0);
        tick();

        // reset in the second RUN cycle aborts without done
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #2;
        check("abort_s", bus.s, 64'd0);
        check("abort_cout", 64'(bus.cout), 64'd0);
        check("abort_ready", 64'(bus.ready), 64'd1);
        check("abort_add", 64'({bus.add_a, bus.add_b, bus.add_cin}), 64'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < K + 2; i++) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        do_op("post_abort", mk(64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001, 1'b1, 1'b0,
                                64'h0000_0000_0002_0001, 1'b0, 1'b0));

        // random back-to-back stream against a W-bit reference sum
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
        rs = 1'($urandom);
`else
        rs = 1'b0;
`endif
        drive(ra, rb, rc, rs);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            exp = model(ra, rb, rc, rs);
            wait_done(lat);
            check("rnd_lat", 64'(lat), 64'(K + 1));
            check("rnd_s", bus.s, exp[W-1:0]);
            check("rnd_cout", 64'(bus.cout), 64'(exp[W]));
            if (i < 1999) begin
                ra = {$urandom, $urandom};
                rb = (i % 7 == 0) ? ~ra : {$urandom, $urandom};
                rc = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
                rs = 1'($urandom);
`endif
                drive(ra, rb, rc, rs);
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
